scurve_scan_controller: RTL and testbench

- Initiator side of the S-curve counter interface.
- Sweeps the threshold DAC from a start code to an end code. At each DAC point it:
  - clears and arms the trigger/pulse counter (Test_Start);
  - generates the charge-injection strobe CLK_EXT;
  - waits for CPT_DONE;
  - captures CPT_PULSE/CPT_TRIGGER;
  - streams a 3-word record into the readout FIFO.
- Sits between the slow-control registers and the per-channel S-curve counter.

---
 rtl/scurve_scan_controller.sv | 257 +++++++++++++++++++++++++
 tb/tb_scurve_scan_controller.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scurve_scan_controller.sv
// S-curve scan initiator: steps the threshold DAC, runs one injection burst per
// point against the pulse/trigger counter and streams a 3-word record per point.
module scurve_scan_controller #(
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd1000000,
  parameter logic [15:0] TRAILER_WORD   = 16'hFF45
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        Scan_Start,
  input  logic        Scan_Abort,
  input  logic [9:0]  DAC_Start,
  input  logic [9:0]  DAC_End,
  input  logic [9:0]  DAC_Step,
  input  logic [15:0] CPT_MAX,
  input  logic [15:0] Pulse_Period,
  input  logic [15:0] Pulse_High,
  input  logic [15:0] Settle_Time,
  output logic [9:0]  DAC_Code,
  output logic        DAC_Load,
  output logic        CLK_EXT,
  output logic        Test_Start,
  output logic        Counter_Reset_n,
  input  logic [15:0] CPT_PULSE,
  input  logic [15:0] CPT_TRIGGER,
  input  logic        CPT_DONE,
  output logic [15:0] Data_Out,
  output logic        Data_Valid,
  input  logic        Data_Ready,
  output logic        Scan_Busy,
  output logic        Scan_Done
);
  typedef enum logic [3:0] {
    IDLE, LOAD, CLEAR, SETTLE, RUN, WAIT_DONE, OUT0, OUT1, OUT2, NEXT, TRAILER, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  dac_q, dac_d, end_q, end_d, step_q, step_d;
  logic        up_q, up_d, tmo_q, tmo_d;
  logic [15:0] npulse_q, npulse_d, period_q, period_d, high_q, high_d, settle_q, settle_d;
  logic [19:0] cnt_q, cnt_d;
  logic [15:0] p_q, p_d, pcnt_q, pcnt_d;
  logic [15:0] cap_pulse_q, cap_pulse_d, cap_trig_q, cap_trig_d;
  logic        dac_load_q, dac_load_d, clk_ext_q, clk_ext_d, test_start_q, test_start_d;
  logic        crst_n_q, crst_n_d, dvalid_q, dvalid_d, busy_q, busy_d, done_q, done_d;
  logic [15:0] dout_q, dout_d;

  logic [15:0] per_eff, high_eff;
  logic [10:0] next_code;
  logic        next_stop;
  logic [20:0] cnt_inc;

  // The counter's 2-FF edge detector needs at least 2 cycles high and 2 low.
  function automatic logic [15:0] sat_period(input logic [15:0] p);
    return (p < 16'd4) ? 16'd4 : p;
  endfunction

  function automatic logic [15:0] sat_high(input logic [15:0] h, input logic [15:0] per);
    if (h < 16'd2) return 16'd2;
    if (h > per - 16'd2) return per - 16'd2;
    return h;
  endfunction

  assign per_eff   = sat_period(Pulse_Period);
  assign high_eff  = sat_high(Pulse_High, per_eff);
  assign next_code = up_q ? ({1'b0, dac_q} + {1'b0, step_q}) : ({1'b0, dac_q} - {1'b0, step_q});
  // Bit 10 flags overflow past 1023 going up, or a borrow going down.
  assign next_stop = up_q ? (next_code > {1'b0, end_q}) : (next_code[10] || (next_code[9:0] < end_q));
  assign cnt_inc   = {1'b0, cnt_q} + 21'd1;

  always_comb begin
    state_d     = state_q;
    dac_d       = dac_q;
    end_d       = end_q;
    step_d      = step_q;
    up_d        = up_q;
    tmo_d       = tmo_q;
    npulse_d    = npulse_q;
    period_d    = period_q;
    high_d      = high_q;
    settle_d    = settle_q;
    cnt_d       = cnt_q;
    p_d         = p_q;
    pcnt_d      = pcnt_q;
    cap_pulse_d = cap_pulse_q;
    cap_trig_d  = cap_trig_q;
    clk_ext_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (Scan_Start && !Scan_Abort) begin
          dac_d    = DAC_Start;
          end_d    = DAC_End;
          up_d     = (DAC_End >= DAC_Start);
          step_d   = (DAC_Step == 10'd0) ? 10'd1 : DAC_Step;
          npulse_d = (CPT_MAX == 16'd0) ? 16'd1 : CPT_MAX;
          period_d = per_eff;
          high_d   = high_eff;
          settle_d = Settle_Time;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = 20'd0;
        state_d = CLEAR;
      end
      CLEAR: begin
        if (cnt_q[0]) begin
          cnt_d   = 20'd0;
          p_d     = 16'd0;
          pcnt_d  = 16'd0;
          state_d = (settle_q == 16'd0) ? RUN : SETTLE;
        end else begin
          cnt_d = cnt_inc[19:0];
        end
      end
      SETTLE: begin
        if (cnt_inc >= {5'd0, settle_q}) begin
          p_d     = 16'd0;
          pcnt_d  = 16'd0;
          state_d = RUN;
        end else begin
          cnt_d = cnt_inc[19:0];
        end
      end
      RUN: begin
        if (CPT_DONE) begin
          cap_pulse_d = CPT_PULSE;
          cap_trig_d  = CPT_TRIGGER;
          tmo_d       = 1'b0;
          state_d     = OUT0;
        end else begin
          clk_ext_d = (p_q < high_q);
          if (p_q == period_q - 16'd1) begin
            p_d    = 16'd0;
            pcnt_d = pcnt_q + 16'd1;
            if (pcnt_q == npulse_q - 16'd1) begin
              cnt_d   = 20'd0;
              state_d = WAIT_DONE;
            end
          end else begin
            p_d = p_q + 16'd1;
          end
        end
      end
      WAIT_DONE: begin
        if (CPT_DONE) begin
          cap_pulse_d = CPT_PULSE;
          cap_trig_d  = CPT_TRIGGER;
          tmo_d       = 1'b0;
          state_d     = OUT0;
        end else if (cnt_inc >= {1'b0, TIMEOUT_CYCLES}) begin
          cap_pulse_d = CPT_PULSE;
          cap_trig_d  = CPT_TRIGGER;
          tmo_d       = 1'b1;
          state_d     = OUT0;
        end else begin
          cnt_d = cnt_inc[19:0];
        end
      end
      OUT0:    if (Data_Ready) state_d = OUT1;
      OUT1:    if (Data_Ready) state_d = OUT2;
      OUT2:    if (Data_Ready) state_d = NEXT;
      NEXT: begin
        if (next_stop) begin
          state_d = TRAILER;
        end else begin
          dac_d   = next_code[9:0];
          state_d = LOAD;
        end
      end
      TRAILER: if (Data_Ready) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (Scan_Abort && state_q != IDLE) begin
      state_d   = IDLE;
      clk_ext_d = 1'b0;
    end

    // Outputs are decoded from the next state so they register with it.
    dac_load_d   = (state_d == LOAD);
    crst_n_d     = (state_d != CLEAR);
    test_start_d = (state_d == RUN) || (state_d == WAIT_DONE);
    busy_d       = (state_d != IDLE) && (state_d != DONE);
    done_d       = (state_d == DONE);
    dvalid_d     = (state_d == OUT0) || (state_d == OUT1) || (state_d == OUT2) || (state_d == TRAILER);
    case (state_d)
      OUT0:    dout_d = {4'hA, tmo_d, 1'b0, dac_d};
      OUT1:    dout_d = cap_pulse_d;
      OUT2:    dout_d = cap_trig_d;
      TRAILER: dout_d = TRAILER_WORD;
      default: dout_d = dout_q;
    endcase
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      dac_q        <= 10'd0;
      end_q        <= 10'd0;
      step_q       <= 10'd1;
      up_q         <= 1'b1;
      tmo_q        <= 1'b0;
      npulse_q     <= 16'd1;
      period_q     <= 16'd4;
      high_q       <= 16'd2;
      settle_q     <= 16'd0;
      cnt_q        <= 20'd0;
      p_q          <= 16'd0;
      pcnt_q       <= 16'd0;
      cap_pulse_q  <= 16'd0;
      cap_trig_q   <= 16'd0;
      dac_load_q   <= 1'b0;
      clk_ext_q    <= 1'b0;
      test_start_q <= 1'b0;
      crst_n_q     <= 1'b0;
      dvalid_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      dout_q       <= 16'd0;
    end else begin
      state_q      <= state_d;
      dac_q        <= dac_d;
      end_q        <= end_d;
      step_q       <= step_d;
      up_q         <= up_d;
      tmo_q        <= tmo_d;
      npulse_q     <= npulse_d;
      period_q     <= period_d;
      high_q       <= high_d;
      settle_q     <= settle_d;
      cnt_q        <= cnt_d;
      p_q          <= p_d;
      pcnt_q       <= pcnt_d;
      cap_pulse_q  <= cap_pulse_d;
      cap_trig_q   <= cap_trig_d;
      dac_load_q   <= dac_load_d;
      clk_ext_q    <= clk_ext_d;
      test_start_q <= test_start_d;
      crst_n_q     <= crst_n_d;
      dvalid_q     <= dvalid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      dout_q       <= dout_d;
    end
  end

  assign DAC_Code        = dac_q;
  assign DAC_Load        = dac_load_q;
  assign CLK_EXT         = clk_ext_q;
  assign Test_Start      = test_start_q;
  assign Counter_Reset_n = crst_n_q;
  assign Data_Out        = dout_q;
  assign Data_Valid      = dvalid_q;
  assign Scan_Busy       = busy_q;
  assign Scan_Done       = done_q;
endmodule

// File: tb/tb_scurve_scan_controller.sv
// Bench for scurve_scan_controller: directed scans against a behavioural
// pulse/trigger counter, with a word scoreboard and CLK_EXT shape monitor.
module tb_scurve_scan_controller;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        scan_start = 1'b0, scan_abort = 1'b0;
  logic [9:0]  dac_start = '0, dac_end = '0, dac_step = '0;
  logic [15:0] cpt_max = '0, pulse_period = '0, pulse_high = '0, settle_time = '0;
  logic [9:0]  dac_code;
  logic        dac_load, clk_ext, test_start, crst_n;
  logic [15:0] cpt_pulse, cpt_trigger;
  logic        cpt_done;
  logic [15:0] data_out;
  logic        data_valid, scan_busy, scan_done;
  logic        data_ready = 1'b1;

  always #5 clk = ~clk;

  scurve_scan_controller #(.TIMEOUT_CYCLES(20'd100), .TRAILER_WORD(16'hFF45)) dut (
    .Clk(clk), .reset(reset), .Scan_Start(scan_start), .Scan_Abort(scan_abort),
    .DAC_Start(dac_start), .DAC_End(dac_end), .DAC_Step(dac_step), .CPT_MAX(cpt_max),
    .Pulse_Period(pulse_period), .Pulse_High(pulse_high), .Settle_Time(settle_time),
    .DAC_Code(dac_code), .DAC_Load(dac_load), .CLK_EXT(clk_ext), .Test_Start(test_start),
    .Counter_Reset_n(crst_n), .CPT_PULSE(cpt_pulse), .CPT_TRIGGER(cpt_trigger),
    .CPT_DONE(cpt_done), .Data_Out(data_out), .Data_Valid(data_valid),
    .Data_Ready(data_ready), .Scan_Busy(scan_busy), .Scan_Done(scan_done)
  );

  // Behavioural counter: counts CLK_EXT rises while enabled, signals done
  // once the target is reached and the strobe is back low.
  logic [15:0] m_cnt = '0, m_trg = '0, m_max = 16'd1;
  logic        m_prev = 1'b0, m_sent = 1'b0;
  logic        done_en = 1'b1, trig_all = 1'b1;
  initial cpt_done = 1'b0;
  assign cpt_pulse   = m_cnt;
  assign cpt_trigger = m_trg;

  always @(posedge clk) begin
    if (!crst_n) begin
      m_cnt    <= '0;
      m_trg    <= '0;
      m_sent   <= 1'b0;
      cpt_done <= 1'b0;
    end else begin
      cpt_done <= 1'b0;
      if (test_start && clk_ext && !m_prev) begin
        m_cnt <= m_cnt + 16'd1;
        if (trig_all || !m_cnt[0]) m_trg <= m_trg + 16'd1;
      end
      if (done_en && !m_sent && test_start && (m_cnt >= m_max) && !clk_ext) begin
        cpt_done <= 1'b1;
        m_sent   <= 1'b1;
      end
    end
    m_prev <= clk_ext;
  end

  int n_cmp = 0, n_err = 0;
  logic [15:0] exp_q[$];
  int load_q[$];
  int pulse_q[$];
  int done_cnt = 0, rises = 0, hi_cur = 0, cyc = 0, last_rise = 0;
  int hi_min = 9999, hi_max = 0, per_min = 9999, per_max = 0;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp_v, exp_v);
    end
  endtask

  // Monitor: scoreboard pops on every transfer; also logs loads, done pulses, strobe shape.
  initial begin : monitor
    logic [15:0] w;
    logic ce_prev, ts_prev;
    ce_prev = 1'b0;
    ts_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (data_valid && data_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL word: got %h with no word expected", data_out);
        end else begin
          w = exp_q.pop_front();
          if (data_out !== w) begin
            n_err++;
            $display("FAIL word: got %h expected %h", data_out, w);
          end
        end
      end
      if (dac_load) load_q.push_back(int'(dac_code));
      if (scan_done) done_cnt++;
      if (clk_ext && !ce_prev) begin
        if (rises > 0) begin
          if (cyc - last_rise < per_min) per_min = cyc - last_rise;
          if (cyc - last_rise > per_max) per_max = cyc - last_rise;
        end
        rises++;
        last_rise = cyc;
        hi_cur = 1;
      end else if (clk_ext) begin
        hi_cur++;
      end
      if (!clk_ext && ce_prev) begin
        if (hi_cur < hi_min) hi_min = hi_cur;
        if (hi_cur > hi_max) hi_max = hi_cur;
      end
      if (!test_start && ts_prev) begin
        pulse_q.push_back(rises);
        rises = 0;
      end
      ce_prev = clk_ext;
      ts_prev = test_start;
      cyc++;
    end
  end

  task automatic clear_stats();
    load_q.delete();
    pulse_q.delete();
    done_cnt = 0; rises = 0;
    hi_min = 9999; hi_max = 0; per_min = 9999; per_max = 0;
  endtask

  task automatic cfg(input int s, input int e, input int st, input int cm,
                     input int per, input int hi, input int stl);
    dac_start = 10'(s); dac_end = 10'(e); dac_step = 10'(st);
    cpt_max = 16'(cm); pulse_period = 16'(per); pulse_high = 16'(hi);
    settle_time = 16'(stl);
    m_max = (cm == 0) ? 16'd1 : 16'(cm);
    clear_stats();
  endtask

  task automatic push3(input logic [15:0] h, input logic [15:0] p, input logic [15:0] t);
    exp_q.push_back(h); exp_q.push_back(p); exp_q.push_back(t);
  endtask

  task automatic start_scan();
    @(posedge clk); #1 scan_start = 1'b1;
    @(posedge clk); #1 scan_start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    bit idle = 0;
    for (int i = 0; i < 20000 && !idle; i++) begin
      @(posedge clk); #1;
      if (!scan_busy) idle = 1;
    end
    chk({nm, " idle reached"}, int'(idle), 1);
    repeat (3) @(posedge clk);
    #1 chk({nm, " words left"}, exp_q.size(), 0);
  endtask

  task automatic chk_loads(input string nm, input int first, input int delta, input int n);
    chk({nm, " load count"}, load_q.size(), n);
    for (int i = 0; i < load_q.size() && i < n; i++)
      chk({nm, " load code"}, load_q[i], first + i * delta);
  endtask

  task automatic chk_pulses(input string nm, input int pts, input int each);
    chk({nm, " points"}, pulse_q.size(), pts);
    for (int i = 0; i < pulse_q.size(); i++) chk({nm, " pulses"}, pulse_q[i], each);
  endtask

  task automatic wait_word(input string nm, input logic [15:0] w);
    bit found = 0;
    for (int i = 0; i < 5000 && !found; i++) begin
      @(negedge clk);
      if (data_valid && data_out == w) found = 1;
    end
    chk({nm, " word seen"}, int'(found), 1);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int bad;
    // Reset state
    @(posedge clk); #1;
    chk("rst dac_code", dac_code, 0);
    chk("rst crst_n", crst_n, 0);
    chk("rst clk_ext", clk_ext, 0);
    chk("rst test_start", test_start, 0);
    chk("rst valid", data_valid, 0);
    chk("rst data_out", data_out, 0);
    chk("rst busy", scan_busy, 0);
    chk("rst done", scan_done, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("post-rst crst_n", crst_n, 1);

    // Start and abort together in IDLE: abort wins
    clear_stats();
    scan_start = 1'b1; scan_abort = 1'b1;
    @(posedge clk); #1;
    chk("start+abort busy", scan_busy, 0);
    scan_start = 1'b0; scan_abort = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("start+abort loads", load_q.size(), 0);

    // Test 1: up sweep 100..102
    cfg(100, 102, 1, 10, 8, 4, 3);
    push3(16'hA064, 16'h000A, 16'h000A);
    push3(16'hA065, 16'h000A, 16'h000A);
    push3(16'hA066, 16'h000A, 16'h000A);
    exp_q.push_back(16'hFF45);
    start_scan();
    wait_idle("t1");
    chk_loads("t1", 100, 1, 3);
    chk_pulses("t1", 3, 10);
    chk("t1 high min", hi_min, 4);
    chk("t1 high max", hi_max, 4);
    chk("t1 period min", per_min, 8);
    chk("t1 period max", per_max, 8);
    chk("t1 done pulses", done_cnt, 1);
    chk("t1 final code", dac_code, 102);

    // Test 2a: down sweep 5..0 step 2, trigger on odd pulses only
    trig_all = 1'b0;
    cfg(5, 0, 2, 3, 8, 4, 0);
    push3(16'hA005, 16'h0003, 16'h0002);
    push3(16'hA003, 16'h0003, 16'h0002);
    push3(16'hA001, 16'h0003, 16'h0002);
    exp_q.push_back(16'hFF45);
    start_scan();
    wait_idle("t2a");
    chk_loads("t2a", 5, -2, 3);
    chk("t2a done pulses", done_cnt, 1);
    trig_all = 1'b1;

    // Test 2b: 1020..1023 step 5, no wrap
    cfg(1020, 1023, 5, 1, 8, 4, 0);
    push3(16'hA3FC, 16'h0001, 16'h0001);
    exp_q.push_back(16'hFF45);
    start_scan();
    wait_idle("t2b");
    chk_loads("t2b", 1020, 5, 1);

    // Test 3a: step 0, period 3, high 1, CPT_MAX 0
    cfg(10, 11, 0, 0, 3, 1, 0);
    push3(16'hA00A, 16'h0001, 16'h0001);
    push3(16'hA00B, 16'h0001, 16'h0001);
    exp_q.push_back(16'hFF45);
    start_scan();
    wait_idle("t3a");
    chk_loads("t3a", 10, 1, 2);
    chk_pulses("t3a", 2, 1);
    chk("t3a high min", hi_min, 2);
    chk("t3a high max", hi_max, 2);

    // Test 3b: same clamping with two pulses to observe the period
    cfg(20, 20, 0, 2, 3, 1, 0);
    push3(16'hA014, 16'h0002, 16'h0002);
    exp_q.push_back(16'hFF45);
    start_scan();
    wait_idle("t3b");
    chk_pulses("t3b", 1, 2);
    chk("t3b period", per_max, 4);
    chk("t3b period min", per_min, 4);
    chk("t3b high", hi_max, 2);

    // Test 4: backpressure on OUT1
    cfg(100, 100, 1, 10, 8, 4, 0);
    push3(16'hA064, 16'h000A, 16'h000A);
    exp_q.push_back(16'hFF45);
    start_scan();
    wait_word("t4 header", 16'hA064);
    @(posedge clk); #1 data_ready = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!data_valid || data_out !== 16'h000A) bad++;
    end
    chk("t4 stall hold", bad, 0);
    @(posedge clk); #1 data_ready = 1'b1;
    wait_idle("t4");
    chk("t4 done pulses", done_cnt, 1);

    // Test 5: no CPT_DONE, timeout closes each point
    done_en = 1'b0;
    cfg(100, 101, 1, 3, 8, 4, 0);
    push3(16'hA864, 16'h0003, 16'h0003);
    push3(16'hA865, 16'h0003, 16'h0003);
    exp_q.push_back(16'hFF45);
    start_scan();
    wait_idle("t5");
    chk_loads("t5", 100, 1, 2);
    chk("t5 done pulses", done_cnt, 1);
    done_en = 1'b1;

    // Test 6a: abort during RUN
    cfg(200, 202, 1, 10, 8, 4, 0);
    start_scan();
    begin
      bit seen = 0;
      for (int i = 0; i < 2000 && !seen; i++) begin
        @(negedge clk);
        if (clk_ext) seen = 1;
      end
      chk("t6a run reached", int'(seen), 1);
    end
    scan_abort = 1'b1;
    @(posedge clk); #1;
    chk("t6a clk_ext", clk_ext, 0);
    chk("t6a test_start", test_start, 0);
    chk("t6a valid", data_valid, 0);
    chk("t6a busy", scan_busy, 0);
    scan_abort = 1'b0;
    repeat (30) @(posedge clk);
    #1 chk("t6a done pulses", done_cnt, 0);
    chk("t6a words left", exp_q.size(), 0);

    // Test 6b: asynchronous reset while OUT1 is pending
    cfg(300, 300, 1, 2, 8, 4, 0);
    exp_q.push_back(16'hA12C);
    start_scan();
    wait_word("t6b header", 16'hA12C);
    @(posedge clk); #1 data_ready = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t6b valid", data_valid, 0);
    chk("t6b crst_n", crst_n, 0);
    chk("t6b busy", scan_busy, 0);
    chk("t6b dac_code", dac_code, 0);
    chk("t6b data_out", data_out, 0);
    chk("t6b test_start", test_start, 0);
    @(posedge clk); #1 reset = 1'b0; data_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("t6b done pulses", done_cnt, 0);
    chk("t6b words left", exp_q.size(), 0);

    // Test 6c: a fresh scan after abort/reset runs normally
    cfg(50, 51, 1, 2, 8, 4, 1);
    push3(16'hA032, 16'h0002, 16'h0002);
    push3(16'hA033, 16'h0002, 16'h0002);
    exp_q.push_back(16'hFF45);
    start_scan();
    wait_idle("t6c");
    chk_pulses("t6c", 2, 2);
    chk("t6c done pulses", done_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
